ps2_frame_rx: RTL and testbench
===============================

PS2_FRAME_RX -- requirements
Module: ps2_frame_rx

Interface
REQ-001 Parameter: FILTER_LEN, default 8, consecutive stable synchronized samples required before the filtered PS/2 clock changes level.
REQ-002 Parameter: TIMEOUT_CYCLES, default 50000, clk cycles without a filtered falling edge that abort a frame in progress (1 ms at 50 MHz).
REQ-003 Port: clk  input  1  system clock; all logic in this single domain.
REQ-004 Port: rst_n  input  1  asynchronous active-low reset.
REQ-005 Port: ps2k_clk  input  1  raw PS/2 clock from the keyboard, asynchronous to clk.
REQ-006 Port: ps2k_data  input  1  raw PS/2 data from the keyboard, asynchronous to clk.
REQ-007 Port: code  output  8  last delivered scan code; held between deliveries.
REQ-008 Port: code_valid  output  1  one-cycle pulse when code, is_break and is_ext are updated.
REQ-009 Port: is_break  output  1  delivered code was preceded by 0xF0; held with code.
REQ-010 Port: is_ext  output  1  delivered code was preceded by 0xE0; held with code.
REQ-011 Port: frame_err  output  1  one-cycle pulse on parity error, stop error or timeout.

Function
REQ-012 ps2k_clk and ps2k_data SHALL each pass through a 2-flop synchronizer before any use.
REQ-013 The filtered clock SHALL take the synchronized clock level only after that level has been stable for FILTER_LEN consecutive cycles; shorter pulses are ignored.
REQ-014 A sample event SHALL be one cycle in which the filtered clock goes 1->0; data is taken from the synchronized data in that cycle.
REQ-015 The FSM SHALL have the states IDLE, DATA, PARITY and STOP.
REQ-016 IDLE: on a sample event with data=0 (start bit), go to DATA with the bit count cleared; with data=1, stay in IDLE with no error.
REQ-017 DATA: shift in 8 bits LSB first; go to PARITY after the 8th bit.
REQ-018 PARITY: store the parity bit; go to STOP.
REQ-019 STOP: the frame is good when stop=1 and the 8 data bits plus parity contain an odd number of ones; the FSM returns to IDLE either way.
REQ-020 Good byte 0xE0: set ext_pending; no code_valid.
REQ-021 Good byte 0xF0: set brk_pending; no code_valid.
REQ-022 Good byte of any other value: load code, set is_break=brk_pending and is_ext=ext_pending, pulse code_valid, then clear both pendings.
REQ-023 code_valid SHALL assert exactly 1 cycle after the sample event of the stop bit.
REQ-024 Bad frame: pulse frame_err 1 cycle after the stop-bit sample event, discard the byte, clear both pendings, leave code/is_break/is_ext unchanged.
REQ-025 Outside IDLE, the timeout counter SHALL reset on each sample event and otherwise increment.
REQ-026 When the timeout counter reaches TIMEOUT_CYCLES: go to IDLE, pulse frame_err once, clear both pendings.
REQ-027 In IDLE, the timeout counter SHALL be held at 0, and pendings SHALL persist across idle gaps of any length.
REQ-028 code_valid and frame_err SHALL never assert in the same cycle.
REQ-029 Sequence E0 F0 xx SHALL deliver xx with is_ext=1 and is_break=1; F0 E0 xx SHALL give the same result.

Reset
REQ-030 While rst_n=0: code=0x00, code_valid=0, is_break=0, is_ext=0, frame_err=0, FSM=IDLE, pendings, counters and shift register cleared, and synchronizer and filter flops set to 1 (bus idle).
REQ-031 Reset asserted mid-frame SHALL abandon the frame without a frame_err pulse; the first frame after release SHALL decode normally.

Verification
REQ-032 Make code: frame start 0, data 0x1C, parity 0, stop 1 -> single code_valid, code=0x1C, is_break=0, is_ext=0.
REQ-033 Break code: frames F0 then 1C -> exactly one code_valid, code=0x1C, is_break=1, is_ext=0.
REQ-034 Extended break: frames E0, F0, 75 -> one code_valid, code=0x75, is_ext=1, is_break=1; a following frame 1C gives is_ext=0 and is_break=0.
REQ-035 Parity error: data 0x1C with parity 1 -> frame_err pulse, no code_valid, code keeps its previous value; the next good 0x1C frame is delivered.
REQ-036 Timeout: start bit plus 4 data bits, then clock held high for TIMEOUT_CYCLES -> one frame_err, FSM=IDLE; a following good 0x29 frame gives code=0x29.
REQ-037 Glitch and reset: a 3-cycle low pulse on ps2k_clk with FILTER_LEN=8 -> no bit sampled; rst_n pulsed after 6 bits -> all outputs 0, no frame_err, and the next 0x1C frame is delivered.

Source files
------------

// File: rtl/ps2_frame_rx.sv
// PS/2 keyboard frame receiver: synchronizes and deglitches the PS/2 lines,
// decodes 11-bit frames and folds E0/F0 prefixes into is_ext/is_break flags.
module ps2_frame_rx #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2k_clk,
  input  logic       ps2k_data,
  output logic [7:0] code,
  output logic       code_valid,
  output logic       is_break,
  output logic       is_ext,
  output logic       frame_err
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [FW-1:0] FLT_LAST = FW'(FILTER_LEN - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  state_t        state;
  logic          clk_s1, clk_s2, data_s1, data_s2;
  logic          filt_clk, filt_prev;
  logic [FW-1:0] flt_cnt;
  logic [TW-1:0] tmo_cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift;
  logic          par_bit;
  logic          ext_pending, brk_pending;
  logic          fall;

  assign fall = filt_prev & ~filt_clk;

  // Sync flops and filter reset to 1 so the bus looks idle out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_s1    <= 1'b1;
      clk_s2    <= 1'b1;
      data_s1   <= 1'b1;
      data_s2   <= 1'b1;
      filt_clk  <= 1'b1;
      filt_prev <= 1'b1;
      flt_cnt   <= '0;
    end else begin
      clk_s1    <= ps2k_clk;
      clk_s2    <= clk_s1;
      data_s1   <= ps2k_data;
      data_s2   <= data_s1;
      filt_prev <= filt_clk;
      if (clk_s2 == filt_clk) begin
        flt_cnt <= '0;
      end else if (flt_cnt == FLT_LAST) begin
        filt_clk <= clk_s2;
        flt_cnt  <= '0;
      end else begin
        flt_cnt <= flt_cnt + FW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      tmo_cnt     <= '0;
      bit_cnt     <= '0;
      shift       <= '0;
      par_bit     <= 1'b0;
      ext_pending <= 1'b0;
      brk_pending <= 1'b0;
      code        <= '0;
      code_valid  <= 1'b0;
      is_break    <= 1'b0;
      is_ext      <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      code_valid <= 1'b0;
      frame_err  <= 1'b0;
      if (state == IDLE || fall) tmo_cnt <= '0;
      else                       tmo_cnt <= tmo_cnt + TW'(1);

      if (state != IDLE && !fall && tmo_cnt == TMO_LAST) begin
        state       <= IDLE;
        frame_err   <= 1'b1;
        ext_pending <= 1'b0;
        brk_pending <= 1'b0;
      end else if (fall) begin
        case (state)
          IDLE: begin
            if (!data_s2) begin
              state   <= DATA;
              bit_cnt <= '0;
            end
          end
          DATA: begin
            shift   <= {data_s2, shift[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state <= PARITY;
          end
          PARITY: begin
            par_bit <= data_s2;
            state   <= STOP;
          end
          STOP: begin
            state <= IDLE;
            // Good frame needs stop=1 and odd parity over data plus parity bit.
            if (data_s2 && (^{shift, par_bit})) begin
              if (shift == 8'hE0) begin
                ext_pending <= 1'b1;
              end else if (shift == 8'hF0) begin
                brk_pending <= 1'b1;
              end else begin
                code        <= shift;
                is_break    <= brk_pending;
                is_ext      <= ext_pending;
                code_valid  <= 1'b1;
                ext_pending <= 1'b0;
                brk_pending <= 1'b0;
              end
            end else begin
              frame_err   <= 1'b1;
              ext_pending <= 1'b0;
              brk_pending <= 1'b0;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ps2_frame_rx.sv
// Scoreboard bench for ps2_frame_rx: a byte-level model queues expected
// deliveries/errors and a monitor pops them as the DUT pulses its outputs.
module tb_ps2_frame_rx;

  localparam int FILTER_LEN     = 8;
  localparam int TIMEOUT_CYCLES = 2000;
  localparam int HALF           = 30;

  typedef struct packed {
    logic       err;
    logic [7:0] code;
    logic       brk;
    logic       ext;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ps2k_clk = 1'b1;
  logic       ps2k_data = 1'b1;
  logic [7:0] code;
  logic       code_valid, is_break, is_ext, frame_err;

  exp_t       expQ[$];
  int         checks = 0;
  int         failures = 0;
  logic       mBrk = 1'b0, mExt = 1'b0;
  logic [7:0] lastCode = 8'h00;
  logic       lastBrk = 1'b0, lastExt = 1'b0;

  ps2_frame_rx #(.FILTER_LEN(FILTER_LEN), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)) dut (
    .clk(clk), .rst_n(rst_n), .ps2k_clk(ps2k_clk), .ps2k_data(ps2k_data),
    .code(code), .code_valid(code_valid), .is_break(is_break), .is_ext(is_ext),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    if (obs !== expv) begin
      failures++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic sendBit(input logic b);
    ps2k_data = b;
    repeat (HALF) @(posedge clk);
    ps2k_clk = 1'b0;
    repeat (HALF) @(posedge clk);
    ps2k_clk = 1'b1;
  endtask

  task automatic sendPartial(input logic [7:0] b, input int nbits);
    sendBit(1'b0);
    for (int i = 0; i < nbits; i++) sendBit(b[i]);
    ps2k_data = 1'b1;
  endtask

  // Model the decoder at byte level, queue the outcome, then drive the frame.
  task automatic applyStimulus(input logic [7:0] b, input logic badParity);
    exp_t e;
    if (badParity) begin
      e = '{err: 1'b1, code: lastCode, brk: lastBrk, ext: lastExt};
      expQ.push_back(e);
      mBrk = 1'b0;
      mExt = 1'b0;
    end else if (b == 8'hE0) begin
      mExt = 1'b1;
    end else if (b == 8'hF0) begin
      mBrk = 1'b1;
    end else begin
      lastCode = b;
      lastBrk  = mBrk;
      lastExt  = mExt;
      e = '{err: 1'b0, code: b, brk: mBrk, ext: mExt};
      expQ.push_back(e);
      mBrk = 1'b0;
      mExt = 1'b0;
    end
    sendBit(1'b0);
    for (int i = 0; i < 8; i++) sendBit(b[i]);
    sendBit((~^b) ^ badParity);
    sendBit(1'b1);
    repeat (2 * HALF) @(posedge clk);
  endtask

  // Every pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rst_n && (code_valid || frame_err)) begin
      checkOutput("pulse_exclusive", {31'd0, code_valid & frame_err}, 32'd0);
      if (expQ.size() == 0) begin
        checkOutput("unexpected_pulse", {31'd0, frame_err}, 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = expQ.pop_front();
        checkOutput("pulse_is_err", {31'd0, frame_err}, {31'd0, e.err});
        checkOutput("code", {24'd0, code}, {24'd0, e.code});
        checkOutput("is_break", {31'd0, is_break}, {31'd0, e.brk});
        checkOutput("is_ext", {31'd0, is_ext}, {31'd0, e.ext});
      end
    end
  end

  task automatic checkResetOutputs(input string tag);
    @(negedge clk);
    checkOutput({tag, "_code"}, {24'd0, code}, 32'd0);
    checkOutput({tag, "_valid"}, {31'd0, code_valid}, 32'd0);
    checkOutput({tag, "_break"}, {31'd0, is_break}, 32'd0);
    checkOutput({tag, "_ext"}, {31'd0, is_ext}, 32'd0);
    checkOutput({tag, "_err"}, {31'd0, frame_err}, 32'd0);
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while (expQ.size() != 0 && n < 500) begin
      @(posedge clk);
      n++;
    end
    checkOutput(tag, expQ.size(), 32'd0);
  endtask

  initial begin
    logic [7:0] r;
    repeat (5) @(posedge clk);
    checkResetOutputs("rst");
    rst_n = 1'b1;
    repeat (20) @(posedge clk);

    applyStimulus(8'h1C, 1'b0);
    applyStimulus(8'hF0, 1'b0);
    applyStimulus(8'h1C, 1'b0);
    applyStimulus(8'hE0, 1'b0);
    applyStimulus(8'hF0, 1'b0);
    applyStimulus(8'h75, 1'b0);
    applyStimulus(8'h1C, 1'b0);
    applyStimulus(8'hF0, 1'b0);
    applyStimulus(8'hE0, 1'b0);
    applyStimulus(8'h6B, 1'b0);

    applyStimulus(8'h1C, 1'b1);
    applyStimulus(8'h1C, 1'b0);
    applyStimulus(8'hE0, 1'b0);
    applyStimulus(8'h33, 1'b1);
    applyStimulus(8'h1C, 1'b0);

    // Timeout mid-frame after a pending prefix.
    applyStimulus(8'hF0, 1'b0);
    expQ.push_back('{err: 1'b1, code: lastCode, brk: lastBrk, ext: lastExt});
    mBrk = 1'b0;
    mExt = 1'b0;
    sendPartial(8'h29, 4);
    repeat (TIMEOUT_CYCLES + 200) @(posedge clk);
    drain("timeout_drain");
    applyStimulus(8'h29, 1'b0);

    // A short clock glitch with data low must not look like a start bit.
    ps2k_data = 1'b0;
    ps2k_clk  = 1'b0;
    repeat (3) @(posedge clk);
    ps2k_clk  = 1'b1;
    repeat (50) @(posedge clk);
    ps2k_data = 1'b1;
    repeat (50) @(posedge clk);
    applyStimulus(8'h1C, 1'b0);

    for (int i = 0; i < 4; i++) begin
      r = 8'($urandom_range(1, 8'hDF));
      applyStimulus(r, 1'b0);
    end
    drain("pre_reset_drain");

    // Reset mid-frame with a pending prefix: everything clears silently.
    applyStimulus(8'hE0, 1'b0);
    sendPartial(8'h5A, 6);
    rst_n = 1'b0;
    repeat (5) @(posedge clk);
    checkResetOutputs("midrst");
    rst_n = 1'b1;
    mBrk = 1'b0;
    mExt = 1'b0;
    lastCode = 8'h00;
    lastBrk = 1'b0;
    lastExt = 1'b0;
    repeat (50) @(posedge clk);
    applyStimulus(8'h1C, 1'b0);

    drain("final_drain");
    repeat (20) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
